// File: rtl/ddr3_cke_lane_ctrl_if.sv
// ddr3_cke_lane_ctrl_if: CKE request, serial word, delay-line command and lane-control signals.
interface ddr3_cke_lane_ctrl_if #(parameter int STEP_W = 8);
  logic              CKE_REQ;
  logic [1:0]        CKE_PHASE;
  logic              CKE_VALID;
  logic              CKE_READY;
  logic [3:0]        TX_DATA;
  logic [3:0]        OE_DATA;
  logic              DL_START;
  logic [STEP_W-1:0] DL_STEPS;
  logic              DL_DIR;
  logic              DL_LOAD_REQ;
  logic              DL_BUSY;
  logic              DL_DONE;
  logic              DL_OOR_STICKY;
  logic              DL_OOR_CLR;
  logic              DELAY_LINE_MOVE;
  logic              DELAY_LINE_DIRECTION;
  logic              DELAY_LINE_LOAD;
  logic              DELAY_LINE_OUT_OF_RANGE;
  modport master (
    output CKE_REQ, CKE_PHASE, CKE_VALID, DL_START, DL_STEPS, DL_DIR, DL_LOAD_REQ, DL_OOR_CLR,
           DELAY_LINE_OUT_OF_RANGE,
    input  CKE_READY, TX_DATA, OE_DATA, DL_BUSY, DL_DONE, DL_OOR_STICKY,
           DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
  );
  modport slave (
    input  CKE_REQ, CKE_PHASE, CKE_VALID, DL_START, DL_STEPS, DL_DIR, DL_LOAD_REQ, DL_OOR_CLR,
           DELAY_LINE_OUT_OF_RANGE,
    output CKE_READY, TX_DATA, OE_DATA, DL_BUSY, DL_DONE, DL_OOR_STICKY,
           DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD
  );
endinterface

// File: rtl/ddr3_cke_lane_ctrl.sv
// ddr3_cke_lane_ctrl: DDR3 CKE lane driver (serial CKE words, tCKE hold, delay-line sequencer).
// Define CKE_LANE_OOR_SYNC_EN to pass DELAY_LINE_OUT_OF_RANGE through a 2-flop synchroniser.
module ddr3_cke_lane_ctrl #(
  parameter int MIN_HOLD    = 4,
  parameter int OE_INIT_DLY = 8,
  parameter int STEP_W      = 8
) (
  input logic FAB_CLK,
  input logic ARST,
  ddr3_cke_lane_ctrl_if.slave lane
);
  localparam int HOLD_W = 4;
  typedef enum logic [2:0] {S_IDLE, S_MOVE_HI, S_MOVE_LO, S_LOAD, S_DONE} dl_state_t;
  logic [7:0]        r_oe_cnt;
  logic              r_oe;
  logic              r_level;
  logic [HOLD_W-1:0] r_hold;
  logic [3:0]        r_tx;
  logic [3:0]        w_mix;
  logic              w_accept;
  logic              w_oor;
  dl_state_t         r_state;
  dl_state_t         w_next;
  logic [STEP_W-1:0] r_rem;
  logic              r_dir;
  logic              r_sticky;
  always_ff @(posedge FAB_CLK or posedge ARST)
    if (ARST) begin
      r_oe_cnt <= '0;
      r_oe     <= 1'b0;
    end else if (!r_oe) begin
      r_oe_cnt <= r_oe_cnt + 8'd1;
      r_oe     <= (r_oe_cnt == 8'(OE_INIT_DLY - 1));
    end
  assign w_accept = lane.CKE_VALID & lane.CKE_READY;
  // Slots before the phase keep the old level, the rest carry the new one.
  always_comb begin
    w_mix = '0;
    for (int i = 0; i < 4; i++) w_mix[i] = (i < int'(lane.CKE_PHASE)) ? r_level : lane.CKE_REQ;
  end
  always_ff @(posedge FAB_CLK or posedge ARST)
    if (ARST) begin
      r_level <= 1'b0;
      r_hold  <= '0;
      r_tx    <= '0;
    end else begin
      r_tx    <= w_accept ? w_mix : {4{r_level}};
      r_level <= w_accept ? lane.CKE_REQ : r_level;
      r_hold  <= (w_accept && lane.CKE_REQ != r_level) ? HOLD_W'(MIN_HOLD) :
                 (r_hold != '0) ? r_hold - 1'b1 : r_hold;
    end
  assign lane.CKE_READY = r_oe & (r_hold == '0);
  assign lane.TX_DATA   = r_tx;
  assign lane.OE_DATA   = {4{r_oe}};
`ifdef CKE_LANE_OOR_SYNC_EN
  logic [1:0] r_oor_sync;
  always_ff @(posedge FAB_CLK or posedge ARST)
    if (ARST) r_oor_sync <= '0;
    else r_oor_sync <= {r_oor_sync[0], lane.DELAY_LINE_OUT_OF_RANGE};
  assign w_oor = r_oor_sync[1];
`else
  assign w_oor = lane.DELAY_LINE_OUT_OF_RANGE;
`endif
  always_ff @(posedge FAB_CLK or posedge ARST)
    if (ARST) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = lane.DL_LOAD_REQ ? S_LOAD :
                          lane.DL_START ? ((lane.DL_STEPS != '0) ? S_MOVE_HI : S_DONE) : S_IDLE;
      S_MOVE_HI: w_next = w_oor ? S_DONE : S_MOVE_LO;
      S_MOVE_LO: w_next = (w_oor || r_rem == '0) ? S_DONE : S_MOVE_HI;
      S_LOAD:    w_next = S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge FAB_CLK or posedge ARST)
    if (ARST) begin
      r_rem    <= '0;
      r_dir    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      if (r_state == S_IDLE && !lane.DL_LOAD_REQ && lane.DL_START && lane.DL_STEPS != '0) begin
        r_rem <= lane.DL_STEPS;
        r_dir <= lane.DL_DIR;
      end else if (r_state == S_MOVE_HI) begin
        r_rem <= r_rem - 1'b1;
      end
      r_sticky <= w_oor | (r_sticky & ~lane.DL_OOR_CLR);
    end
  always_comb begin
    lane.DL_BUSY              = r_state != S_IDLE;
    lane.DL_DONE              = r_state == S_DONE;
    lane.DELAY_LINE_MOVE      = r_state == S_MOVE_HI;
    lane.DELAY_LINE_LOAD      = r_state == S_LOAD;
    lane.DELAY_LINE_DIRECTION = r_dir;
    lane.DL_OOR_STICKY        = r_sticky;
  end
endmodule

// File: tb/tb_ddr3_cke_lane_ctrl.sv
// tb_ddr3_cke_lane_ctrl: random stimulus, queue scoreboard against a plan-based reference model.
module tb_ddr3_cke_lane_ctrl;
  localparam int MIN_HOLD = 4, OE_INIT_DLY = 8, STEP_W = 8, NCYC = 4000;
  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;
  ddr3_cke_lane_ctrl_if #(.STEP_W(STEP_W)) bus();
  ddr3_cke_lane_ctrl #(.MIN_HOLD(MIN_HOLD), .OE_INIT_DLY(OE_INIT_DLY), .STEP_W(STEP_W))
    dut (.FAB_CLK(clk), .ARST(arst), .lane(bus));
  logic [14:0] w_obs;
  assign w_obs = {bus.TX_DATA, bus.OE_DATA, bus.CKE_READY, bus.DL_BUSY, bus.DL_DONE, bus.DL_OOR_STICKY,
                  bus.DELAY_LINE_MOVE, bus.DELAY_LINE_DIRECTION, bus.DELAY_LINE_LOAD};
  int total = 0, bad = 0;
  logic [14:0] exp_q[$];
  bit chk_en = 1'b0;
  int n, hold;
  logic lvl, rdy, dir, stk, oor_d1, oor_d2;
  logic [3:0] tx;
  int plan[$];
  task automatic check(string name, logic [14:0] act, logic [14:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @%0t: got tx=%h oe=%h rdy,busy,done,stk,mv,dir,ld=%b want tx=%h oe=%h rdy,busy,done,stk,mv,dir,ld=%b",
               name, $time, act[14:11], act[10:7], act[6:0], want[14:11], want[10:7], want[6:0]);
    end
  endtask
  task automatic model_reset();
    n = 0; hold = 0; lvl = 0; rdy = 0; dir = 0; stk = 0; oor_d1 = 0; oor_d2 = 0; tx = 0;
    plan.delete();
  endtask
  // Plan entries: 1 = move pulse cycle, 2 = gap cycle, 3 = load cycle, 4 = done cycle.
  task automatic model_step();
    logic acc, oor_e;
    logic [3:0] mix;
    int head;
`ifdef CKE_LANE_OOR_SYNC_EN
    oor_e = oor_d2; oor_d2 = oor_d1; oor_d1 = bus.DELAY_LINE_OUT_OF_RANGE;
`else
    oor_e = bus.DELAY_LINE_OUT_OF_RANGE;
`endif
    acc = bus.CKE_VALID && rdy;
    for (int i = 0; i < 4; i++) mix[i] = (i < int'(bus.CKE_PHASE)) ? lvl : bus.CKE_REQ;
    if (acc) begin
      tx = mix;
      if (bus.CKE_REQ != lvl) hold = MIN_HOLD;
      lvl = bus.CKE_REQ;
    end else begin
      tx = {4{lvl}};
      if (hold > 0) hold--;
    end
    n++;
    rdy = (n >= OE_INIT_DLY) && hold == 0;
    if (plan.size() == 0) begin
      if (bus.DL_LOAD_REQ) plan = '{3, 4};
      else if (bus.DL_START) begin
        if (bus.DL_STEPS != 0) begin
          dir = bus.DL_DIR;
          for (int k = 0; k < int'(bus.DL_STEPS); k++) begin plan.push_back(1); plan.push_back(2); end
        end
        plan.push_back(4);
      end
    end else if (oor_e && plan[0] <= 2) plan = '{4};
    else void'(plan.pop_front());
    stk = oor_e ? 1'b1 : (bus.DL_OOR_CLR ? 1'b0 : stk);
    head = (plan.size() != 0) ? plan[0] : 0;
    exp_q.push_back({tx, {4{n >= OE_INIT_DLY}}, rdy, plan.size() != 0, head == 4, stk,
                     head == 1, dir, head == 3});
  endtask
  task automatic drive_idle();
    bus.CKE_REQ = 0; bus.CKE_PHASE = 0; bus.CKE_VALID = 0; bus.DL_START = 0; bus.DL_STEPS = 0;
    bus.DL_DIR = 0; bus.DL_LOAD_REQ = 0; bus.DL_OOR_CLR = 0; bus.DELAY_LINE_OUT_OF_RANGE = 0;
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_underflow @%0t: got empty queue want an entry", $time);
      end else check("cycle", w_obs, exp_q.pop_front());
    end
  end
  initial begin
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1 check("reset_state", w_obs, 15'd0);
    @(negedge clk);
    arst = 1'b0;
    chk_en = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1 model_step();
      if (c >= NCYC - 20) drive_idle();
      else begin
        bus.CKE_VALID = 1'($urandom % 2);
        bus.CKE_REQ   = 1'($urandom % 2);
        bus.CKE_PHASE = 2'($urandom % 4);
        bus.DL_START  = ($urandom % 10) == 0;
        bus.DL_STEPS  = STEP_W'($urandom % 6);
        bus.DL_DIR    = 1'($urandom % 2);
        bus.DL_LOAD_REQ = ($urandom % 25) == 0;
        bus.DL_OOR_CLR  = ($urandom % 6) == 0;
        bus.DELAY_LINE_OUT_OF_RANGE = ($urandom % 30) == 0;
      end
    end
    #2 chk_en = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    bus.DL_START = 1; bus.DL_STEPS = 5; bus.DL_DIR = 1;
    @(posedge clk);
    #1 bus.DL_START = 0;
    total++;
    if ({bus.DELAY_LINE_MOVE, bus.DL_BUSY, bus.DELAY_LINE_DIRECTION} !== 3'b111) begin
      bad++;
      $display("FAIL move_hi_entry: got mv,busy,dir=%b want 111",
               {bus.DELAY_LINE_MOVE, bus.DL_BUSY, bus.DELAY_LINE_DIRECTION});
    end
    #2 arst = 1'b1;
    #1 check("arst_mid_move", w_obs, 15'd0);
    @(negedge clk);
    arst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("oe_counter_restarted", w_obs, 15'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
